pc_fetch_ctrl: RTL and testbench

- Fetch-stage sequencer for the 5-stage pipeline.
- Owns the architectural fetch PC and issues single-outstanding requests to instruction memory over a request/grant/rvalid handshake.
- Delivers fetched instructions to IF/ID through a one-entry registered output buffer.
- Arbitrates the next PC between trap redirect, EX-stage branch/jump redirect, stall and sequential PC+4, and squashes stale in-flight fetches after a redirect.

---
 rtl/pc_fetch_ctrl.sv | 112 +++++++++++
 tb/tb_pc_fetch_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, issues single-outstanding imem requests,
// buffers one instruction for IF/ID and squashes stale fetches after trap/branch redirects.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_redirect,
  input  logic [31:0] br_target,
  input  logic        trap_redirect,
  input  logic [31:0] trap_vector,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        flush,
  output logic [31:0] fetch_pc
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q, pc_nxt;
  logic [31:0] inflight_pc, inflight_nxt;
  logic        kill, kill_nxt;
  logic        if_valid_nxt;
  logic [31:0] if_pc_nxt, if_instr_nxt;
  logic        redir;
  logic [31:0] redir_target;

  // Redirects are ignored in BOOT; trap beats branch and targets are forced word aligned.
  assign redir        = (state != S_BOOT) && (trap_redirect || br_redirect);
  assign redir_target = {(trap_redirect ? trap_vector[31:2] : br_target[31:2]), 2'b00};

  assign imem_addr = pc_q;
  assign fetch_pc  = pc_q;
  assign flush     = redir;

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc_q;
    inflight_nxt = inflight_pc;
    kill_nxt     = kill;
    if_valid_nxt = if_valid && stall;
    if_pc_nxt    = if_pc;
    if_instr_nxt = if_instr;
    imem_req     = 1'b0;

    case (state)
      S_BOOT: state_nxt = S_REQ;
      S_REQ: begin
        imem_req = !redir && (!if_valid || !stall);
        if (imem_req && imem_gnt) begin
          inflight_nxt = pc_q;
          pc_nxt       = pc_q + 32'd4;
          state_nxt    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_nxt = S_REQ;
          if (!kill && !redir) begin
            if_valid_nxt = 1'b1;
            if_pc_nxt    = inflight_pc;
            if_instr_nxt = imem_rdata;
          end else begin
            kill_nxt = 1'b0;
          end
        end else if (redir) begin
          // The in-flight response now belongs to a squashed path.
          kill_nxt = 1'b1;
        end
      end
      default: state_nxt = S_BOOT;
    endcase

    if (redir) begin
      pc_nxt       = redir_target;
      if_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_BOOT;
      pc_q        <= RESET_PC;
      inflight_pc <= 32'd0;
      kill        <= 1'b0;
      if_valid    <= 1'b0;
      if_pc       <= 32'd0;
      if_instr    <= 32'd0;
    end else begin
      state       <= state_nxt;
      pc_q        <= pc_nxt;
      inflight_pc <= inflight_nxt;
      kill        <= kill_nxt;
      if_valid    <= if_valid_nxt;
      if_pc       <= if_pc_nxt;
      if_instr    <= if_instr_nxt;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: a small imem model with configurable latency drives
// responses; all checks happen at the falling edge against hand-computed values.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, br_redirect, trap_redirect;
  logic [31:0] br_target, trap_vector;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid, flush;
  logic [31:0] if_pc, if_instr, fetch_pc;

  logic        imem_req2, if_valid2, flush2;
  logic [31:0] imem_addr2, if_pc2, if_instr2, fetch_pc2;
  logic        rvalid2 = 1'b0;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          mem_lat = 0;
  int          wait_cnt = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'd0;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .br_redirect(br_redirect), .br_target(br_target),
    .trap_redirect(trap_redirect), .trap_vector(trap_vector),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .flush(flush), .fetch_pc(fetch_pc)
  );

  pc_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .stall(1'b0),
    .br_redirect(1'b0), .br_target(32'd0),
    .trap_redirect(1'b0), .trap_vector(32'd0),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_gnt(1'b1),
    .imem_rvalid(rvalid2), .imem_rdata(32'd0),
    .if_valid(if_valid2), .if_pc(if_pc2), .if_instr(if_instr2),
    .flush(flush2), .fetch_pc(fetch_pc2)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One clock: sample the grant for the coming edge, then model imem at the next falling edge.
  task automatic tick();
    logic g;
    #1;
    g = imem_req && imem_gnt;
    if (g) pend_addr = imem_addr;
    @(posedge clk);
    @(negedge clk);
    imem_rvalid = 1'b0;
    if (g) begin
      pend     = 1'b1;
      wait_cnt = mem_lat;
    end
    if (pend) begin
      if (wait_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word(pend_addr);
        pend        = 1'b0;
      end else begin
        wait_cnt--;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; br_redirect = 1'b0; trap_redirect = 1'b0;
    br_target = 32'd0; trap_vector = 32'd0; imem_gnt = 1'b1;
    imem_rvalid = 1'b0; imem_rdata = 32'd0;
    repeat (2) @(negedge clk);

    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_fetch_pc", fetch_pc, 32'd0);
    chk("rst_wrap_pc", fetch_pc2, 32'hFFFF_FFFC);

    // Sequential fetch 0,4,8 with single-cycle memory.
    rst_n = 1'b1;
    tick();
    chk("boot_req", {31'd0, imem_req}, 32'd1);
    chk("addr0", imem_addr, 32'd0);
    chk("wrap_addr0", imem_addr2, 32'hFFFF_FFFC);
    tick();
    chk("wait_req", {31'd0, imem_req}, 32'd0);
    chk("pc_after_gnt", fetch_pc, 32'd4);
    chk("wrap_pc", fetch_pc2, 32'd0);
    chk("wrap_addr1", imem_addr2, 32'd0);
    tick();
    chk("v0", {31'd0, if_valid}, 32'd1);
    chk("pc0", if_pc, 32'd0);
    chk("instr0", if_instr, word(32'd0));
    chk("addr4", imem_addr, 32'd4);
    chk("req4", {31'd0, imem_req}, 32'd1);
    tick();
    chk("consumed", {31'd0, if_valid}, 32'd0);
    tick();
    chk("pc4", if_pc, 32'd4);
    chk("instr4", if_instr, word(32'd4));
    chk("addr8", imem_addr, 32'd8);
    tick();
    tick();
    chk("pc8", if_pc, 32'd8);
    chk("instr8", if_instr, word(32'd8));

    // Stall holds the buffer and blocks requests for three cycles.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      chk("stall_v", {31'd0, if_valid}, 32'd1);
      chk("stall_pc", if_pc, 32'd8);
      tick();
    end
    stall = 1'b0;
    #1;
    chk("unstall_req", {31'd0, imem_req}, 32'd1);
    chk("addr12", imem_addr, 32'd12);
    tick();

    // Branch redirect while the response for 12 arrives: it is discarded.
    br_redirect = 1'b1; br_target = 32'h100;
    #1;
    chk("br_flush", {31'd0, flush}, 32'd1);
    tick();
    br_redirect = 1'b0;
    #1;
    chk("br_drop", {31'd0, if_valid}, 32'd0);
    chk("br_noflush", {31'd0, flush}, 32'd0);
    chk("br_addr", imem_addr, 32'h100);
    chk("br_req", {31'd0, imem_req}, 32'd1);
    tick();
    tick();
    chk("br_pc", if_pc, 32'h100);
    chk("br_instr", if_instr, word(32'h100));

    // Trap beats branch in the same cycle.
    trap_redirect = 1'b1; trap_vector = 32'h200;
    br_redirect = 1'b1; br_target = 32'h100;
    #1;
    chk("tr_flush", {31'd0, flush}, 32'd1);
    chk("tr_noreq", {31'd0, imem_req}, 32'd0);
    tick();
    trap_redirect = 1'b0; br_redirect = 1'b0;
    #1;
    chk("tr_addr", imem_addr, 32'h200);
    chk("tr_clear", {31'd0, if_valid}, 32'd0);

    // Redirect while waiting on a slow response: kill drops the late data.
    mem_lat = 1;
    tick();
    br_redirect = 1'b1; br_target = 32'h103;
    #1;
    chk("kill_flush", {31'd0, flush}, 32'd1);
    tick();
    br_redirect = 1'b0;
    #1;
    chk("align_pc", fetch_pc, 32'h100);
    chk("kill_wait_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("kill_drop", {31'd0, if_valid}, 32'd0);
    chk("kill_req", {31'd0, imem_req}, 32'd1);
    chk("kill_addr", imem_addr, 32'h100);
    mem_lat = 0;
    tick();
    tick();
    chk("kill_v", {31'd0, if_valid}, 32'd1);
    chk("kill_pc", if_pc, 32'h100);
    chk("kill_instr", if_instr, word(32'h100));

    // Redirect with stall: redirect wins and clears the buffer.
    stall = 1'b1; br_redirect = 1'b1; br_target = 32'h300;
    tick();
    stall = 1'b0; br_redirect = 1'b0;
    #1;
    chk("rs_clear", {31'd0, if_valid}, 32'd0);
    chk("rs_pc", fetch_pc, 32'h300);

    // Reset pulsed during WAIT, stale rvalid arriving in BOOT.
    mem_lat = 1;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pc", fetch_pc, 32'd0);
    chk("mid_rst_v", {31'd0, if_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    mem_lat = 0;
    pend = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("stale_v", {31'd0, if_valid}, 32'd0);
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'd0);
    tick();
    tick();
    chk("post_rst_pc", if_pc, 32'd0);
    chk("post_rst_instr", if_instr, word(32'd0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
